// File: rtl/divisor_1600.sv
// Registered line index: posVertical = floor(cntVertical / DIVISOR), one clock of latency.
// Optional macro DIV1600_REM_EN adds the registered remainder output remHorizontal.
module divisor_1600 #(
  parameter int CNT_W   = 20,
  parameter int POS_W   = 10,
  parameter int DIVISOR = 1600
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cntVertical,
`ifdef DIV1600_REM_EN
  output logic [10:0]      remHorizontal,
`endif
  output logic [POS_W-1:0] posVertical
);

  localparam int REM_W = $clog2(DIVISOR) + 1;
  localparam logic [REM_W:0] DIV_EXT = (REM_W + 1)'(DIVISOR);

  // partRem[i] is the partial remainder entering stage i (MSB-first)
  logic [CNT_W-1:0][REM_W-1:0] partRem;
  logic [CNT_W-1:0]            quotient;
  logic [POS_W-1:0]            quotSat;
`ifdef DIV1600_REM_EN
  logic [REM_W-1:0]            remFinal;
`endif

  assign partRem[0] = '0;

  for (genvar i = 0; i < CNT_W; i++) begin : gStage
    localparam int BIT = CNT_W - 1 - i;
    logic [REM_W:0] trial;

    assign trial         = {partRem[i], cntVertical[BIT]};
    assign quotient[BIT] = (trial >= DIV_EXT);

    // A restored remainder is always below DIVISOR, so REM_W bits suffice
    if (i < CNT_W - 1) begin : gMid
      assign partRem[i+1] = quotient[BIT] ? REM_W'(trial - DIV_EXT) : REM_W'(trial);
    end else begin : gLast
`ifdef DIV1600_REM_EN
      assign remFinal = quotient[BIT] ? REM_W'(trial - DIV_EXT) : REM_W'(trial);
`endif
    end
  end

  if (CNT_W > POS_W) begin : gSat
    assign quotSat = (|quotient[CNT_W-1:POS_W]) ? {POS_W{1'b1}} : quotient[POS_W-1:0];
  end else begin : gNoSat
    assign quotSat = POS_W'(quotient);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      posVertical   <= '0;
`ifdef DIV1600_REM_EN
      remHorizontal <= '0;
`endif
    end else begin
      posVertical   <= quotSat;
`ifdef DIV1600_REM_EN
      remHorizontal <= 11'(remFinal);
`endif
    end
  end

endmodule

// File: tb/tb_divisor_1600.sv
// Bench for divisor_1600: directed boundaries, partial sweeps, reset cases and random values
// checked against an arithmetic reference model (quotient/remainder via integer division).
module tb_divisor_1600;
  localparam int CNT_W   = 20;
  localparam int POS_W   = 10;
  localparam int DIVISOR = 1600;
  localparam int POS_MAX = (1 << POS_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] cntVertical;
  logic [POS_W-1:0] posVertical;
`ifdef DIV1600_REM_EN
  logic [10:0]      remHorizontal;
`endif

  int checks = 0;
  int errors = 0;
  logic [POS_W-1:0] prevPos;
  bit               prevValid = 1'b0;
  int               hist [0:POS_MAX];

  divisor_1600 #(.CNT_W(CNT_W), .POS_W(POS_W), .DIVISOR(DIVISOR)) dut (
    .clk          (clk),
    .reset        (reset),
    .cntVertical  (cntVertical),
`ifdef DIV1600_REM_EN
    .remHorizontal(remHorizontal),
`endif
    .posVertical  (posVertical)
  );

  always #5 clk = ~clk;

  function automatic int refPos(input logic [CNT_W-1:0] v);
    int q;
    q = int'(v) / DIVISOR;
    return (q > POS_MAX) ? POS_MAX : q;
  endfunction

  // Apply one value for one clock; the output must hold until the edge, then show the result.
  task automatic drive(input logic [CNT_W-1:0] v, input logic rst, input string name);
    logic [POS_W-1:0] expPos;
    @(negedge clk);
    cntVertical = v;
    reset       = rst;
    #1;
    if (prevValid) begin
      checks++;
      if (posVertical !== prevPos) begin
        errors++;
        $display("FAIL %s hold before edge: posVertical=%0d expected=%0d", name, posVertical, prevPos);
      end
    end
    @(posedge clk);
    #1;
    expPos = rst ? '0 : POS_W'(refPos(v));
    checks++;
    if (posVertical !== expPos) begin
      errors++;
      $display("FAIL %s cnt=%0d rst=%0b: posVertical=%0d expected=%0d", name, v, rst, posVertical, expPos);
    end
`ifdef DIV1600_REM_EN
    begin
      logic [10:0] expRem;
      expRem = rst ? '0 : 11'(int'(v) % DIVISOR);
      checks++;
      if (remHorizontal !== expRem) begin
        errors++;
        $display("FAIL %s rem cnt=%0d: remHorizontal=%0d expected=%0d", name, v, remHorizontal, expRem);
      end
    end
`endif
    prevPos   = expPos;
    prevValid = 1'b1;
  endtask

  task automatic test_reset();
    prevValid = 1'b0;
    drive(20'd5000, 1'b1, "reset_cyc1");
    drive(20'd5000, 1'b1, "reset_cyc2");
    drive(20'd5000, 1'b0, "reset_release");
  endtask

  task automatic test_line_edges();
    logic [CNT_W-1:0] vals [5] = '{20'd0, 20'd1599, 20'd1600, 20'd3199, 20'd3200};
    foreach (vals[i]) drive(vals[i], 1'b0, "line_edges");
  endtask

  task automatic test_frame_wrap();
    drive(20'd839999, 1'b0, "frame_wrap_end");
    drive(20'd840000, 1'b0, "frame_wrap_525");
    drive(20'd0,      1'b0, "frame_wrap_zero");
  endtask

  task automatic test_extremes();
    drive(20'd1048575, 1'b0, "extreme_max");
    drive(20'd3201,    1'b0, "extreme_3201");
    drive(20'd1,       1'b0, "extreme_one");
    drive(20'd1048575, 1'b0, "extreme_max_again");
  endtask

  task automatic sweepRange(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      drive(CNT_W'(v), 1'b0, "sweep");
      if (!$isunknown(posVertical)) hist[posVertical]++;
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i <= POS_MAX; i++) hist[i] = 0;
    sweepRange(0, 7999);
    sweepRange(832000, 840000);
    for (int q = 0; q <= 4; q++) begin
      checks++;
      if (hist[q] !== 1600) begin
        errors++;
        $display("FAIL sweep_count line %0d: cycles=%0d expected=1600", q, hist[q]);
      end
    end
    for (int q = 520; q <= 524; q++) begin
      checks++;
      if (hist[q] !== 1600) begin
        errors++;
        $display("FAIL sweep_count line %0d: cycles=%0d expected=1600", q, hist[q]);
      end
    end
    checks++;
    if (hist[525] !== 1) begin
      errors++;
      $display("FAIL sweep_count line 525: cycles=%0d expected=1", hist[525]);
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 419997; v <= 420004; v++)
      drive(CNT_W'(v), (v == 420000) ? 1'b1 : 1'b0, "reset_mid");
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 2000; n++)
      drive(CNT_W'($urandom_range(0, (1 << CNT_W) - 1)), 1'b0, "random");
  endtask

  initial begin
    reset       = 1'b1;
    cntVertical = '0;
    test_reset();
    test_line_edges();
    test_frame_wrap();
    test_extremes();
    test_sweep();
    test_reset_mid();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
